chacha_stream_core: RTL and testbench

CHACHA_STREAM_CORE -- requirements
Module: chacha_stream_core

---
 rtl/chacha_stream_core.sv | 188 ++++++++++++++++++
 tb/tb_chacha_stream_core.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_stream_core.sv
// ChaCha keystream core: serial key/counter/nonce load, one quarter-round per cycle, then XOR of din onto dout.
// First din_ready comes 4*ROUNDS+1 edges after the final config beat; din stalls only while dout is held, or during a block recompute.
module chacha_stream_core #(
    parameter int DATA_W = 8,
    parameter int ROUNDS = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din_data,
    output logic              din_ready,
    output logic              dout_valid,
    output logic [DATA_W-1:0] dout_data,
    input  logic              dout_ready,
    output logic              busy
);
    localparam int CFG_BEATS = 384 / DATA_W;
    localparam int KS_BEATS  = 512 / DATA_W;
    localparam int QR_CYCLES = 4 * ROUNDS;
    localparam int CI_W      = $clog2(CFG_BEATS);
    localparam int KI_W      = $clog2(KS_BEATS);
    localparam int RC_W      = $clog2(QR_CYCLES);

    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_ROUND  = 2'd1;
    localparam logic [1:0] S_FINAL  = 2'd2;
    localparam logic [1:0] S_STREAM = 2'd3;

    localparam logic [127:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] quarter(input logic [127:0] abcd);
        logic [31:0] a, b, c, d;
        {a, b, c, d} = abcd;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    logic [1:0]        state_q, state_d;
    logic [383:0]      cfg_q, cfg_d;
    logic [CI_W-1:0]   cfg_idx_q, cfg_idx_d;
    logic [511:0]      ks_q, ks_d;
    logic [KI_W-1:0]   ks_idx_q, ks_idx_d;
    logic [511:0]      ws_q, ws_d;
    logic [RC_W-1:0]   rcnt_q, rcnt_d;
    logic              dout_vld_q, dout_vld_d;
    logic [DATA_W-1:0] dout_dat_q, dout_dat_d;

    logic              ld_fire, din_fire, dout_fire;
    logic [DATA_W-1:0] ks_word;
    logic [511:0]      init_state;
    logic              diag;
    logic [1:0]        lane, lb, lc, ldg;
    logic [8:0]        oa, ob, oc, od;
    logic [127:0]      qr_out;

    assign ld_ready   = (state_q == S_LOAD);
    assign din_ready  = (state_q == S_STREAM) && (!dout_vld_q || dout_ready);
    assign busy       = (state_q == S_ROUND) || (state_q == S_FINAL);
    assign dout_valid = dout_vld_q;
    assign dout_data  = dout_dat_q;

    assign ld_fire    = ld_valid && ld_ready;
    assign din_fire   = din_valid && din_ready;
    assign dout_fire  = dout_vld_q && dout_ready;
    assign ks_word    = ks_q[int'(ks_idx_q) * DATA_W +: DATA_W];
    // cfg layout (key, counter, nonce) already matches state words 4..15
    assign init_state = {cfg_q, SIGMA};

    // Step 0..3 of each group of 8 is a column round, 4..7 the matching diagonal round
    always_comb begin
        diag   = rcnt_q[2];
        lane   = rcnt_q[1:0];
        lb     = lane + {1'b0, diag};
        lc     = lane + {diag, 1'b0};
        ldg    = lane + {diag, diag};
        oa     = {2'b00, lane, 5'd0};
        ob     = {2'b01, lb, 5'd0};
        oc     = {2'b10, lc, 5'd0};
        od     = {2'b11, ldg, 5'd0};
        qr_out = quarter({ws_q[oa +: 32], ws_q[ob +: 32], ws_q[oc +: 32], ws_q[od +: 32]});
    end

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        cfg_idx_d  = cfg_idx_q;
        ks_d       = ks_q;
        ks_idx_d   = ks_idx_q;
        ws_d       = ws_q;
        rcnt_d     = rcnt_q;
        dout_vld_d = dout_vld_q;
        dout_dat_d = dout_dat_q;

        if (dout_fire) dout_vld_d = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (ld_fire) begin
                    cfg_d[int'(cfg_idx_q) * DATA_W +: DATA_W] = ld_data;
                    if (cfg_idx_q == CI_W'(CFG_BEATS - 1)) begin
                        cfg_idx_d = '0;
                        ws_d      = {cfg_d, SIGMA};
                        rcnt_d    = '0;
                        state_d   = S_ROUND;
                    end else begin
                        cfg_idx_d = cfg_idx_q + 1'b1;
                    end
                end
            end
            S_ROUND: begin
                ws_d[oa +: 32] = qr_out[127:96];
                ws_d[ob +: 32] = qr_out[95:64];
                ws_d[oc +: 32] = qr_out[63:32];
                ws_d[od +: 32] = qr_out[31:0];
                if (rcnt_q == RC_W'(QR_CYCLES - 1)) begin
                    state_d = S_FINAL;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            S_FINAL: begin
                for (int j = 0; j < 16; j++) begin
                    ks_d[32*j +: 32] = ws_q[32*j +: 32] + init_state[32*j +: 32];
                end
                state_d = S_STREAM;
            end
            default: begin
                if (din_fire) begin
                    dout_dat_d = din_data ^ ks_word;
                    dout_vld_d = 1'b1;
                    if (ks_idx_q == KI_W'(KS_BEATS - 1)) begin
                        // Block exhausted: bump the counter and recompute from the new input state
                        ks_idx_d          = '0;
                        cfg_d[256 +: 32]  = cfg_q[256 +: 32] + 32'd1;
                        ws_d              = {cfg_d, SIGMA};
                        rcnt_d            = '0;
                        state_d           = S_ROUND;
                    end else begin
                        ks_idx_d = ks_idx_q + 1'b1;
                    end
                end
            end
        endcase

        if (restart) begin
            state_d    = S_LOAD;
            cfg_idx_d  = '0;
            ks_idx_d   = '0;
            rcnt_d     = '0;
            dout_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_LOAD;
            cfg_q      <= '0;
            cfg_idx_q  <= '0;
            ks_q       <= '0;
            ks_idx_q   <= '0;
            ws_q       <= '0;
            rcnt_q     <= '0;
            dout_vld_q <= 1'b0;
            dout_dat_q <= '0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            cfg_idx_q  <= cfg_idx_d;
            ks_q       <= ks_d;
            ks_idx_q   <= ks_idx_d;
            ws_q       <= ws_d;
            rcnt_q     <= rcnt_d;
            dout_vld_q <= dout_vld_d;
            dout_dat_q <= dout_dat_d;
        end
    end
endmodule

// File: tb/tb_chacha_stream_core.sv
// Directed bench for chacha_stream_core: RFC 8439 vectors, counter wrap, backpressure, restart, reset and latency.
module tb_chacha_stream_core;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    always #5 clk = ~clk;

    // 8-bit, 20-round instance
    logic       rs8, ldv8, ldr8, dinv8, dinr8, doutv8, doutr8, busy8;
    logic [7:0] ldd8, dind8, doutd8;
    // 32-bit, 20-round instance
    logic        rs32, ldv32, ldr32, dinv32, dinr32, doutv32, doutr32, busy32;
    logic [31:0] ldd32, dind32, doutd32;
    // 8-bit, 8-round instance
    logic       rsr, ldvr, ldrr, dinvr, dinrr, doutvr, doutrr, busyr;
    logic [7:0] lddr, dindr, doutdr;

    chacha_stream_core #(.DATA_W(8), .ROUNDS(20)) u_dut8 (
        .clk(clk), .reset(reset), .restart(rs8),
        .ld_valid(ldv8), .ld_data(ldd8), .ld_ready(ldr8),
        .din_valid(dinv8), .din_data(dind8), .din_ready(dinr8),
        .dout_valid(doutv8), .dout_data(doutd8), .dout_ready(doutr8),
        .busy(busy8)
    );

    chacha_stream_core #(.DATA_W(32), .ROUNDS(20)) u_dut32 (
        .clk(clk), .reset(reset), .restart(rs32),
        .ld_valid(ldv32), .ld_data(ldd32), .ld_ready(ldr32),
        .din_valid(dinv32), .din_data(dind32), .din_ready(dinr32),
        .dout_valid(doutv32), .dout_data(doutd32), .dout_ready(doutr32),
        .busy(busy32)
    );

    chacha_stream_core #(.DATA_W(8), .ROUNDS(8)) u_dutr8 (
        .clk(clk), .reset(reset), .restart(rsr),
        .ld_valid(ldvr), .ld_data(lddr), .ld_ready(ldrr),
        .din_valid(dinvr), .din_data(dindr), .din_ready(dinrr),
        .dout_valid(doutvr), .dout_data(doutdr), .dout_ready(doutrr),
        .busy(busyr)
    );

    logic [255:0] key;
    logic [95:0]  nonce;
    logic [63:0]  rfc8;
    logic [511:0] blk_a, blk_b;
    logic [7:0]   got8[$];
    logic [31:0]  got32[$];

    function automatic logic [31:0] m_rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] m_qr(input logic [31:0] a_i, input logic [31:0] b_i,
                                          input logic [31:0] c_i, input logic [31:0] d_i);
        logic [31:0] a, b, c, d;
        a = a_i; b = b_i; c = c_i; d = d_i;
        a = a + b; d = d ^ a; d = m_rotl(d, 16);
        c = c + d; b = b ^ c; b = m_rotl(b, 12);
        a = a + b; d = d ^ a; d = m_rotl(d, 8);
        c = c + d; b = b ^ c; b = m_rotl(b, 7);
        return {a, b, c, d};
    endfunction

    // Reference block function: full column round, then full diagonal round
    function automatic logic [511:0] chacha_blk(input logic [255:0] k, input logic [31:0] ctr,
                                                input logic [95:0] n, input int rounds);
        logic [31:0]  s[16];
        logic [31:0]  x[16];
        logic [511:0] o;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int j = 0; j < 8; j++) s[4+j] = k[32*j +: 32];
        s[12] = ctr;
        for (int j = 0; j < 3; j++) s[13+j] = n[32*j +: 32];
        for (int j = 0; j < 16; j++) x[j] = s[j];
        for (int r = 0; r < rounds; r += 2) begin
            {x[0], x[4], x[8],  x[12]} = m_qr(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = m_qr(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = m_qr(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = m_qr(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = m_qr(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = m_qr(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = m_qr(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = m_qr(x[3], x[4], x[9],  x[14]);
        end
        for (int j = 0; j < 16; j++) o[32*j +: 32] = x[j] + s[j];
        return o;
    endfunction

    function automatic logic [7:0] pt(input int i);
        return 8'(i * 7 + 3);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load8(input logic [383:0] cfg, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            @(negedge clk);
            ldv8 = 1'b1;
            ldd8 = cfg[8*k +: 8];
        end
        @(negedge clk);
        ldv8 = 1'b0;
    endtask

    task automatic pulse_restart8();
        @(negedge clk);
        rs8  = 1'b1;
        ldv8 = 1'b1;
        ldd8 = 8'hee;
        @(negedge clk);
        rs8  = 1'b0;
        ldv8 = 1'b0;
    endtask

    task automatic stream8(input int n, input int stall_at, input bit use_pt);
        int       sent;
        int       cyc;
        bit       stalled;
        logic [7:0] held;
        sent    = 0;
        cyc     = 0;
        stalled = 1'b0;
        got8.delete();
        while (got8.size() < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (stall_at >= 0 && !stalled && got8.size() == stall_at) begin
                stalled = 1'b1;
                held    = doutd8;
                doutr8  = 1'b0;
                dinv8   = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    #1;
                    check($sformatf("stall_din_ready[%0d]", i), dinr8, 0);
                    check($sformatf("stall_dout_valid[%0d]", i), doutv8, 1);
                    check($sformatf("stall_dout_hold[%0d]", i), doutd8, held);
                    @(negedge clk);
                end
            end
            doutr8 = 1'b1;
            dinv8  = (sent < n);
            dind8  = use_pt ? pt(sent) : 8'h00;
            #1;
            if (doutv8 && doutr8) got8.push_back(doutd8);
            if (dinv8 && dinr8) sent++;
        end
        dinv8 = 1'b0;
        check("stream8_count", got8.size(), n);
    endtask

    task automatic check_rfc8(input string tag);
        logic [7:0] e;
        for (int i = 0; i < 8; i++) begin
            e = rfc8[8*i +: 8];
            check($sformatf("%s_byte%0d", tag, i), (got8.size() > i) ? got8[i] : 8'hxx, e);
        end
    endtask

    initial begin
        int sent;
        int cyc;
        logic [383:0] cfg;
        logic [7:0]   e;
        logic [31:0]  w0, w1;

        clk = 1'b0; reset = 1'b1; n_chk = 0; n_fail = 0;
        rs8 = 0; ldv8 = 0; ldd8 = 0; dinv8 = 0; dind8 = 0; doutr8 = 1;
        rs32 = 0; ldv32 = 0; ldd32 = 0; dinv32 = 0; dind32 = 0; doutr32 = 1;
        rsr = 0; ldvr = 0; lddr = 0; dinvr = 0; dindr = 0; doutrr = 1;
        for (int i = 0; i < 32; i++) key[8*i +: 8] = 8'(i);
        nonce = '0;
        nonce[24 +: 8] = 8'h09;
        nonce[56 +: 8] = 8'h4a;
        rfc8 = 64'h15593bd1e4e7f110;

        // Outputs while reset is held
        repeat (3) @(negedge clk);
        check("rst_ld_ready", ldr8, 1);
        check("rst_din_ready", dinr8, 0);
        check("rst_dout_valid", doutv8, 0);
        check("rst_dout_data", doutd8, 0);
        check("rst_busy", busy8, 0);
        reset = 1'b0;

        // RFC 8439 block, two full blocks through the 8-bit instance
        cfg = {nonce, 32'd1, key};
        load8(cfg, 48);
        @(negedge clk);
        check("round_busy", busy8, 1);
        check("round_din_ready", dinr8, 0);
        check("round_ld_ready", ldr8, 0);
        stream8(128, -1, 1'b0);
        check_rfc8("rfc_dw8");
        blk_a = chacha_blk(key, 32'd1, nonce, 20);
        blk_b = chacha_blk(key, 32'd2, nonce, 20);
        for (int i = 8; i < 128; i++) begin
            e = (i < 64) ? blk_a[8*i +: 8] : blk_b[8*(i-64) +: 8];
            check($sformatf("blk12_byte%0d", i), got8[i], e);
        end

        // Restart from mid-round, partial load, restart again (with a competing beat), full reload
        pulse_restart8();
        #1;
        check("restart_ld_ready", ldr8, 1);
        check("restart_busy", busy8, 0);
        load8(cfg, 20);
        pulse_restart8();
        load8(cfg, 48);
        stream8(8, -1, 1'b0);
        check_rfc8("restart");

        // Backpressure mid-block with a non-zero plaintext
        pulse_restart8();
        load8(cfg, 48);
        stream8(64, 20, 1'b1);
        for (int i = 0; i < 64; i++) begin
            e = pt(i) ^ blk_a[8*i +: 8];
            check($sformatf("stall_byte%0d", i), got8[i], e);
        end

        // Counter wrap FFFFFFFF -> 00000000
        pulse_restart8();
        load8({nonce, 32'hffffffff, key}, 48);
        stream8(128, -1, 1'b0);
        blk_a = chacha_blk(key, 32'hffffffff, nonce, 20);
        blk_b = chacha_blk(key, 32'h00000000, nonce, 20);
        for (int i = 0; i < 128; i++) begin
            e = (i < 64) ? blk_a[8*i +: 8] : blk_b[8*(i-64) +: 8];
            check($sformatf("wrap_byte%0d", i), got8[i], e);
        end

        // Asynchronous reset while the next block is being computed
        @(negedge clk);
        check("pre_reset_busy", busy8, 1);
        reset = 1'b1;
        #1;
        check("midrst_ld_ready", ldr8, 1);
        check("midrst_busy", busy8, 0);
        check("midrst_din_ready", dinr8, 0);
        check("midrst_dout_valid", doutv8, 0);
        @(negedge clk);
        reset = 1'b0;
        load8(cfg, 48);
        stream8(8, -1, 1'b0);
        check_rfc8("after_reset");

        // 32-bit data path
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            ldv32 = 1'b1;
            ldd32 = cfg[32*k +: 32];
        end
        @(negedge clk);
        ldv32 = 1'b0;
        sent = 0;
        cyc  = 0;
        got32.delete();
        while (got32.size() < 2 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            dinv32 = (sent < 2);
            dind32 = 32'h0;
            #1;
            if (doutv32 && doutr32) got32.push_back(doutd32);
            if (dinv32 && dinr32) sent++;
        end
        dinv32 = 1'b0;
        check("dw32_count", got32.size(), 2);
        w0 = (got32.size() > 0) ? got32[0] : 32'hx;
        w1 = (got32.size() > 1) ? got32[1] : 32'hx;
        check("dw32_word0", w0, 32'he4e7f110);
        check("dw32_word1", w1, 32'h15593bd1);

        // 8-round latency from the final config handshake to first din_ready
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            ldvr = 1'b1;
            lddr = cfg[8*k +: 8];
        end
        @(posedge clk);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            ldvr = 1'b0;
            if (cyc == 0) check("r8_busy", busyr, 1);
            if (dinrr) break;
            @(posedge clk);
            cyc++;
        end
        check("r8_latency", cyc, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
